// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: instruction-fetch stage of the RV32IM pipeline.
// Holds the PC, drives the instruction-memory read handshake and loads the
// IF/ID register. EX redirects (BRANCH_RESET) flush IF/ID with a bubble. A
// redirect that arrives while memory is busy is parked in a pending register
// until the outstanding access drains.
// Optional feature macro: TARGET_ALIGN_CHECK_EN. When it is defined, a taken
// redirect to a non-word-aligned target sets sticky MISALIGNED and freezes
// fetch until reset. When it is not defined, the low two target bits are
// ignored.
module pc_fetch_unit #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR    = 32'h0000_0013
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        STALL,
    input  logic        BRANCH_SELECT,
    input  logic [31:0] TARGET_ADDRESS,
    input  logic        BRANCH_RESET,
    input  logic [31:0] EX_PC,
    output logic        IMEM_READ,
    output logic [31:0] IMEM_ADDRESS,
    input  logic [31:0] IMEM_READDATA,
    input  logic        IMEM_BUSY,
    output logic [31:0] PC,
    output logic [31:0] IF_ID_PC,
    output logic [31:0] IF_ID_PC_PLUS4,
    output logic [31:0] IF_ID_INSTRUCTION,
    output logic        IF_ID_VALID,
    output logic        MISALIGNED
);

    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_FETCH = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t      state_reg, state_next;
    logic [31:0] pc_reg, pc_next;
    logic [31:0] pending_reg, pending_next;
    logic        pending_bad_reg, pending_bad_next;
    logic        imem_read_reg, imem_read_next;
    logic [31:0] ifid_pc_reg, ifid_pc_next;
    logic [31:0] ifid_pc4_reg, ifid_pc4_next;
    logic [31:0] ifid_instr_reg, ifid_instr_next;
    logic        ifid_valid_reg, ifid_valid_next;
    logic        misaligned_reg, misaligned_next;
    logic        frozen_reg, frozen_next;

    logic [31:0] redirect_pc;
    logic        target_bad;
    logic [31:0] pc_plus4;
    logic [31:0] drain_pc;
    logic        drain_bad;

    // Redirect address: taken target (word aligned) or fall-through of the EX instruction.
    always_comb begin
        redirect_pc = BRANCH_SELECT ? (TARGET_ADDRESS & 32'hFFFF_FFFC)
                                    : (EX_PC + 32'd4);
`ifdef TARGET_ALIGN_CHECK_EN
        target_bad  = BRANCH_SELECT && (TARGET_ADDRESS[1:0] != 2'b00);
`else
        target_bad  = 1'b0;
`endif
    end

    // Next-state logic for the fetch FSM, PC, pending redirect and IF/ID.
    always_comb begin
        state_next       = state_reg;
        pc_next          = pc_reg;
        pending_next     = pending_reg;
        pending_bad_next = pending_bad_reg;
        imem_read_next   = imem_read_reg;
        ifid_pc_next     = ifid_pc_reg;
        ifid_pc4_next    = ifid_pc4_reg;
        ifid_instr_next  = ifid_instr_reg;
        ifid_valid_next  = ifid_valid_reg;
        misaligned_next  = misaligned_reg;
        frozen_next      = frozen_reg;
        pc_plus4         = pc_reg + 32'd4;
        drain_pc         = pending_reg;
        drain_bad        = pending_bad_reg;

        case (state_reg)
            ST_BOOT: begin
                state_next     = ST_FETCH;
                imem_read_next = 1'b1;
            end

            ST_FETCH: begin
                if (frozen_reg) begin
                    // Fetch is frozen until reset after a misaligned redirect.
                end else if (BRANCH_RESET) begin
                    ifid_pc_next    = 32'd0;
                    ifid_pc4_next   = 32'd0;
                    ifid_instr_next = NOP_INSTR;
                    ifid_valid_next = 1'b0;
                    if (IMEM_BUSY) begin
                        // The access in flight cannot be aborted, so park the redirect.
                        pending_next     = redirect_pc;
                        pending_bad_next = target_bad;
                        state_next       = ST_DRAIN;
                    end else if (target_bad) begin
                        misaligned_next = 1'b1;
                        frozen_next     = 1'b1;
                        imem_read_next  = 1'b0;
                    end else begin
                        pc_next = redirect_pc;
                    end
                end else if (!IMEM_BUSY && !STALL) begin
                    ifid_pc_next    = pc_reg;
                    ifid_pc4_next   = pc_plus4;
                    ifid_instr_next = IMEM_READDATA;
                    ifid_valid_next = 1'b1;
                    pc_next         = pc_plus4;
                end
            end

            ST_DRAIN: begin
                // The last redirect wins. STALL does not matter while draining.
                if (BRANCH_RESET) begin
                    drain_pc  = redirect_pc;
                    drain_bad = target_bad;
                end
                pending_next     = drain_pc;
                pending_bad_next = drain_bad;
                if (!IMEM_BUSY) begin
                    state_next = ST_FETCH;
                    if (drain_bad) begin
                        misaligned_next = 1'b1;
                        frozen_next     = 1'b1;
                        imem_read_next  = 1'b0;
                    end else begin
                        pc_next = drain_pc;
                    end
                end
            end

            default: begin
                state_next     = ST_BOOT;
                imem_read_next = 1'b0;
            end
        endcase
    end

    // State registers. Reset is asynchronous and abandons any outstanding access.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_reg       <= ST_BOOT;
            pc_reg          <= RESET_VECTOR;
            pending_reg     <= 32'd0;
            pending_bad_reg <= 1'b0;
            imem_read_reg   <= 1'b0;
            ifid_pc_reg     <= 32'd0;
            ifid_pc4_reg    <= 32'd0;
            ifid_instr_reg  <= NOP_INSTR;
            ifid_valid_reg  <= 1'b0;
            misaligned_reg  <= 1'b0;
            frozen_reg      <= 1'b0;
        end else begin
            state_reg       <= state_next;
            pc_reg          <= pc_next;
            pending_reg     <= pending_next;
            pending_bad_reg <= pending_bad_next;
            imem_read_reg   <= imem_read_next;
            ifid_pc_reg     <= ifid_pc_next;
            ifid_pc4_reg    <= ifid_pc4_next;
            ifid_instr_reg  <= ifid_instr_next;
            ifid_valid_reg  <= ifid_valid_next;
            misaligned_reg  <= misaligned_next;
            frozen_reg      <= frozen_next;
        end
    end

    // The fetch address is the PC register itself, so it is glitch-free and held during DRAIN.
    assign IMEM_ADDRESS      = pc_reg;
    assign IMEM_READ         = imem_read_reg;
    assign PC                = pc_reg;
    assign IF_ID_PC          = ifid_pc_reg;
    assign IF_ID_PC_PLUS4    = ifid_pc4_reg;
    assign IF_ID_INSTRUCTION = ifid_instr_reg;
    assign IF_ID_VALID       = ifid_valid_reg;
    assign MISALIGNED        = misaligned_reg;

endmodule

// File: doc/pc_fetch_unit.md
# pc_fetch_unit

Instruction-fetch stage of the RV32IM pipeline. It holds the program counter, drives the instruction-memory read handshake, and loads the IF/ID pipeline register. It consumes the redirect produced by the branch control unit in EX: taken target, select, and two-stage flush request. It guarantees that no wrong-path instruction reaches ID, including when memory is mid-access.

## Interface
Parameters:
- RESET_VECTOR, 32'h0000_0000, PC value loaded on reset
- NOP_INSTR, 32'h0000_0013, bubble (addi x0,x0,0) written into IF/ID on flush

Ports:
- CLK  in  1  rising-edge clock
- RESET  in  1  asynchronous, active-high reset
- STALL  in  1  hazard-unit hold; PC and IF/ID keep their values
- BRANCH_SELECT  in  1  taken jump/branch from EX
- TARGET_ADDRESS  in  32  redirect target, valid when BRANCH_SELECT=1
- BRANCH_RESET  in  1  flush request from EX (any jump/branch)
- EX_PC  in  32  PC of the instruction currently in EX
- IMEM_READ  out  1  read request
- IMEM_ADDRESS  out  32  fetch address
- IMEM_READDATA  in  32  instruction word, valid when IMEM_READ=1 and IMEM_BUSY=0
- IMEM_BUSY  in  1  memory not ready; request must be held
- PC  out  32  current fetch PC
- IF_ID_PC  out  32  PC of the instruction in IF/ID
- IF_ID_PC_PLUS4  out  32  IF_ID_PC + 4
- IF_ID_INSTRUCTION  out  32  instruction word in IF/ID
- IF_ID_VALID  out  1  1 = real instruction, 0 = bubble
- MISALIGNED  out  1  sticky misaligned-target flag (TARGET_ALIGN_CHECK_EN only, else tied 0)

## Operation
- The redirect PC is TARGET_ADDRESS when BRANCH_SELECT=1. Otherwise it is EX_PC+4, which re-fetches the fall-through after the flush. All additions are modulo 2^32, so PC wraps 32'hFFFF_FFFC -> 0.
- FSM states are BOOT, FETCH, DRAIN.
- BOOT: entered on reset. IMEM_READ=0. It moves to FETCH after exactly one clock.
- FETCH: IMEM_READ=1 and IMEM_ADDRESS=PC. Priority per edge is as follows.
  1. BRANCH_RESET with IMEM_BUSY=0: PC <= redirect PC. IF/ID <= bubble. Stay in FETCH.
  2. BRANCH_RESET with IMEM_BUSY=1: the outstanding access cannot be aborted. Latch the redirect PC into the pending register, IF/ID <= bubble, go to DRAIN.
  3. IMEM_BUSY=1: hold PC, IMEM_ADDRESS and IF/ID.
  4. STALL=1: hold PC and IF/ID. The returned word is discarded and re-fetched later.
  5. Otherwise: IF/ID <= {PC, PC+4, IMEM_READDATA, valid=1} and PC <= PC+4.
- DRAIN: IMEM_READ=1 and IMEM_ADDRESS are held at the old PC. IF/ID is held as a bubble.
  - A new BRANCH_RESET overwrites the pending PC (last redirect wins).
  - When IMEM_BUSY=0, the returned word is discarded, PC <= pending PC, and the FSM goes to FETCH. STALL is ignored in DRAIN.
- STALL and BRANCH_RESET in the same cycle: the redirect wins.
- Bubble contents: IF_ID_INSTRUCTION=NOP_INSTR, IF_ID_VALID=0, IF_ID_PC and IF_ID_PC_PLUS4 = 0.

## Timing
- Reset values: PC=RESET_VECTOR, IMEM_ADDRESS=RESET_VECTOR, IMEM_READ=0, IF/ID = bubble, MISALIGNED=0, pending=0, state=BOOT. Reset applies immediately and asynchronously, including mid-DRAIN; the outstanding access is abandoned.
- First fetch: IMEM_READ rises on the first edge after RESET deasserts. With a zero-wait memory, the first instruction sits in IF/ID one edge later.
- Zero-wait throughput is one instruction per cycle. Each busy cycle adds one cycle.
- Redirect latency: the target appears on IMEM_ADDRESS one edge after BRANCH_RESET, or one edge after busy drops if in DRAIN.
- IMEM_ADDRESS and IMEM_READ are registered and glitch-free. They never change while IMEM_BUSY=1.

## Configuration
- TARGET_ALIGN_CHECK_EN defined: a redirect with BRANCH_SELECT=1 and TARGET_ADDRESS[1:0]!=0 does the following:
  - sets MISALIGNED (sticky until RESET);
  - flushes IF/ID;
  - freezes PC with IMEM_READ=0 until reset.
- Undefined: TARGET_ADDRESS[1:0] is forced to 2'b00, no freeze occurs, and MISALIGNED is tied to 0.

## Test plan
- Reset with RESET_VECTOR=0 and zero-wait memory returning addr-tagged words. Required response:
  - IMEM_ADDRESS sequence is 0,4,8,C;
  - IF_ID_PC follows one cycle behind;
  - IF_ID_VALID=1 from the 2nd fetch edge.
- IMEM_BUSY high for 3 cycles at PC=8 -> IMEM_ADDRESS stays 8 for 4 cycles and IF/ID holds PC 4. PC 8 then enters with no duplicate.
- BRANCH_RESET+BRANCH_SELECT with TARGET=0x100 at PC=0x10 -> next IMEM_ADDRESS=0x100 and IF_ID_VALID=0 for one cycle. The next valid IF_ID_PC is 0x100.
- BRANCH_RESET with BRANCH_SELECT=0 and EX_PC=0x20 -> next fetch from 0x24 and IF/ID bubbled.
- Redirect to 0x200 during busy, a second redirect to 0x300 in DRAIN, then busy drops -> the returned word is discarded and the next IMEM_ADDRESS is 0x300.
- With TARGET_ALIGN_CHECK_EN, TARGET=0x102 -> MISALIGNED=1, IMEM_READ=0 and PC frozen. An async RESET mid-freeze restores BOOT and clears MISALIGNED.
